// File: rtl/imm_ext_pipe.sv
// Immediate-extension unit: widens an IN_W-bit immediate to OUT_W bits (zero, sign,
// upper-load, branch-offset) behind a registered output stage with a one-entry skid.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int E = OUT_W - IN_W;

    generate
        if ((IN_W < 2) || (IN_W > OUT_W - 2)) begin : g_bad_width
            $error("imm_ext_pipe: IN_W must lie in 2..OUT_W-2");
        end
    endgenerate

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] imm,
                                             input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{E{imm[IN_W-1]}}, imm};
        case (mode)
            MODE_ZERO:  ext = {{E{1'b0}}, imm};
            MODE_SIGN:  ext = sext;
            MODE_UPPER: ext = {imm, {E{1'b0}}};
            default:    ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    endfunction

    // Handshake: a beat moves on a side only in a cycle where both valid and ready are
    // high at the rising edge; valid never waits for ready, and a presented output
    // (out_data/out_mode) holds until consumed. in_ready comes straight from the skid
    // flag so there is no combinational path from out_ready to in_ready.
    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic [1:0]       m_mode;
    logic             s_valid;
    logic [OUT_W-1:0] s_data;
    logic [1:0]       s_mode;

    logic             acc;
    logic             cons;
    logic [OUT_W-1:0] in_ext;

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_mode  = m_mode;

    assign acc    = in_valid & in_ready;
    assign cons   = m_valid & out_ready;
    assign in_ext = ext(in_imm, in_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_mode  <= 2'b00;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_mode  <= 2'b00;
        end else if (!m_valid) begin
            // Skid is never occupied while the main stage is empty.
            if (acc) begin
                m_valid <= 1'b1;
                m_data  <= in_ext;
                m_mode  <= in_mode;
            end
        end else if (cons) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_mode  <= s_mode;
                s_valid <= 1'b0;
            end else if (acc) begin
                m_data  <= in_ext;
                m_mode  <= in_mode;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= in_ext;
            s_mode  <= in_mode;
        end
    end

endmodule
